alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Execute-stage arithmetic block of the 5-stage MIPS pipeline. Combines three functions:
//  - ALU control decoder: ALUop + funct -> 3-bit ALU operation.
//  - 32-bit ALU with zero flag.
//  - Independent 32-bit adder, used as the branch-target adder (PC+4 + offset<<2).
//  All outputs are registered: results appear one clock after the operands are applied.
// PARAMETERS
//  WIDTH  32  datapath width of ALU operands, ALU result, adder operands and adder sum
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous, active-high reset
//  alu_op     in   3      ALUop from main control
//  funct      in   6      instruction funct field (sign-extended offset [5:0])
//  alu_a      in   WIDTH  ALU operand A (rs data)
//  alu_b      in   WIDTH  ALU operand B (rt data or sign-extended immediate, muxed upstream)
//  add_a      in   WIDTH  adder operand A (incremented PC)
//  add_b      in   WIDTH  adder operand B (shifted offset)
//  alu_ctrl   out  3      registered decoded ALU operation
//  alu_result out  WIDTH  registered ALU result
//  zero       out  1      registered; 1 when alu_result == 0
//  add_sum    out  WIDTH  registered add_a + add_b
// BEHAVIOUR
//  Reset
//  - While reset=1, all outputs are 0, including zero=0. Reset is asynchronous.
//  - The first edge after deassertion loads normal values.
//  Latency
//  - One cycle: on each posedge clk, all outputs load values computed from the current inputs.
//  - No handshake. New operands are accepted every cycle.
//  ALU control decode (alu_op -> alu_ctrl)
//  - 000 -> ADD (lw/sw); 001 -> SUB (beq); 011 -> AND; 100 -> OR; 101 -> SLT; 110/111 -> ADD.
//  - 010 (R-type) decodes funct:
//    - 100000 -> ADD; 100010 -> SUB; 100100 -> AND; 100101 -> OR; 100111 -> NOR; 101010 -> SLT.
//    - Any other funct -> ADD.
//  ALU operation encoding (alu_ctrl)
//  - 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (signed), 100 NOR.
//  - Unused codes 011/101 give result 0.
//  - The ALU uses the freshly decoded ctrl from the same cycle, not the registered alu_ctrl.
//  Arithmetic
//  - ADD/SUB are modulo 2^WIDTH. Overflow is ignored; no exception, no flag.
//  - SLT compares alu_a and alu_b as two's-complement; result is 1 or 0, zero-extended.
//  - zero is computed from the next result value, so it is coherent with alu_result in the same cycle.
//  - add_sum = add_a + add_b modulo 2^WIDTH; carry-out discarded.
//  - add_sum is independent of alu_op and funct.
//  Boundaries
//  - 0x7FFFFFFF + 1 = 0x80000000.
//  - 0 - 1 = 0xFFFFFFFF with zero=0.
//  - SUB of equal operands gives zero=1.
//  - X/Z on inputs need not be masked.
// STRUCTURE
//  - Shared package alu_pkg: ALUop codes, funct codes, alu_ctrl operation codes (localparams).
//  - Sub-module alu_ctrl_dec: purely combinational decoder (alu_op, funct -> ctrl).
//  - ALU datapath, adder and output registers live in the top.
// TESTING
//  1. Assert reset mid-operation with outputs nonzero
//     -> all outputs 0 immediately, without waiting for a clock edge; zero=0.
//  2. alu_op=010, funct=100000, a=5, b=7
//     -> next edge: alu_ctrl=010, alu_result=12, zero=0.
//  3. alu_op=001, a=b=0x1234
//     -> alu_ctrl=110, alu_result=0, zero=1.
//     Then a=0, b=1 -> alu_result=0xFFFFFFFF, zero=0.
//  4. R-type SLT, a=0xFFFFFFFF (-1), b=1 -> alu_result=1.
//     Swap operands -> alu_result=0, zero=1.
//  5. R-type AND/OR/NOR, a=0xF0F0F0F0, b=0xFF00FF00
//     -> 0xF000F000 / 0xFFF0FFF0 / 0x000F000F.
//     Unknown funct 000000 -> ADD.
//  6. add_a=40, add_b=0x10 -> add_sum=56.
//     add_a=0xFFFFFFFC, add_b=8 -> add_sum=4.
//     Issue back-to-back operands each cycle -> each result appears exactly one cycle later.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the execute stage: main-control ALUop codes, R-type funct codes,
// and the 3-bit ALU operation codes driven onto alu_ctrl.
package alu_pkg;

    localparam logic [2:0] ALUOP_MEM   = 3'b000;
    localparam logic [2:0] ALUOP_BEQ   = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE = 3'b010;
    localparam logic [2:0] ALUOP_AND   = 3'b011;
    localparam logic [2:0] ALUOP_OR    = 3'b100;
    localparam logic [2:0] ALUOP_SLT   = 3'b101;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] CTRL_AND = 3'b000;
    localparam logic [2:0] CTRL_OR  = 3'b001;
    localparam logic [2:0] CTRL_ADD = 3'b010;
    localparam logic [2:0] CTRL_NOR = 3'b100;
    localparam logic [2:0] CTRL_SUB = 3'b110;
    localparam logic [2:0] CTRL_SLT = 3'b111;

endpackage

// File: rtl/alu_ctrl_dec.sv
// ALU control decoder: maps ALUop (and funct for R-type) to the ALU operation code.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs continuously.
module alu_ctrl_dec
    import alu_pkg::*;
(
    input  logic [2:0] alu_op,
    input  logic [5:0] funct,
    output logic [2:0] ctrl
);

    always_comb begin
        ctrl = CTRL_ADD;
        case (alu_op)
            ALUOP_MEM: ctrl = CTRL_ADD;
            ALUOP_BEQ: ctrl = CTRL_SUB;
            ALUOP_AND: ctrl = CTRL_AND;
            ALUOP_OR:  ctrl = CTRL_OR;
            ALUOP_SLT: ctrl = CTRL_SLT;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: ctrl = CTRL_ADD;
                    FUNCT_SUB: ctrl = CTRL_SUB;
                    FUNCT_AND: ctrl = CTRL_AND;
                    FUNCT_OR:  ctrl = CTRL_OR;
                    FUNCT_NOR: ctrl = CTRL_NOR;
                    FUNCT_SLT: ctrl = CTRL_SLT;
                    default:   ctrl = CTRL_ADD;
                endcase
            end
            // 110/111 fall back to ADD
            default: ctrl = CTRL_ADD;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU, ALU control decode and branch-target adder with registered outputs.
// Latency: one cycle from operands to alu_ctrl/alu_result/zero/add_sum.
// Backpressure: none; new operands are accepted every cycle.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] add_a,
    input  logic [WIDTH-1:0] add_b,
    output logic [2:0]       alu_ctrl,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero,
    output logic [WIDTH-1:0] add_sum
);

    logic [2:0]       ctrl_nxt;
    logic [WIDTH-1:0] result_nxt;
    logic             a_lt_b;

    alu_ctrl_dec u_dec (
        .alu_op (alu_op),
        .funct  (funct),
        .ctrl   (ctrl_nxt)
    );

    assign a_lt_b = $signed(alu_a) < $signed(alu_b);

    // The datapath uses this cycle's decode so result and alu_ctrl register together.
    always_comb begin
        result_nxt = '0;
        case (ctrl_nxt)
            CTRL_AND: result_nxt = alu_a & alu_b;
            CTRL_OR:  result_nxt = alu_a | alu_b;
            CTRL_ADD: result_nxt = alu_a + alu_b;
            CTRL_SUB: result_nxt = alu_a - alu_b;
            CTRL_NOR: result_nxt = ~(alu_a | alu_b);
            CTRL_SLT: result_nxt = {{(WIDTH-1){1'b0}}, a_lt_b};
            default:  result_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_ctrl   <= '0;
            alu_result <= '0;
            zero       <= 1'b0;
            add_sum    <= '0;
        end else begin
            alu_ctrl   <= ctrl_nxt;
            alu_result <= result_nxt;
            zero       <= (result_nxt == '0);
            add_sum    <= add_a + add_b;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed vector table, reset corner cases and randomized
// operands checked against an operation-level reference model.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  alu_op;
    logic [5:0]  funct;
    logic [31:0] alu_a, alu_b, add_a, add_b;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_result, add_sum;
    logic        zero;

    int n_vec = 0;
    int n_mis = 0;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .alu_op     (alu_op),
        .funct      (funct),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .add_a      (add_a),
        .add_b      (add_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .zero       (zero),
        .add_sum    (add_sum)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [5:0]  fn;
        logic [31:0] a, b, aa, ab;
        logic [2:0]  e_ctrl;
        logic [31:0] e_res;
        logic        e_zero;
        logic [31:0] e_sum;
    } vec_t;

    typedef enum {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_SLT} op_e;

    vec_t tbl[$];

    function automatic vec_t mk(logic [2:0] op, logic [5:0] fn, logic [31:0] a, logic [31:0] b,
                                logic [31:0] aa, logic [31:0] ab, logic [2:0] c, logic [31:0] r,
                                logic z, logic [31:0] s);
        vec_t v;
        v.op = op; v.fn = fn; v.a = a; v.b = b; v.aa = aa; v.ab = ab;
        v.e_ctrl = c; v.e_res = r; v.e_zero = z; v.e_sum = s;
        return v;
    endfunction

    // Reference: pick the MIPS operation by name, then do plain arithmetic on it.
    function automatic vec_t model(logic [2:0] op, logic [5:0] fn, logic [31:0] a, logic [31:0] b,
                                   logic [31:0] aa, logic [31:0] ab);
        vec_t  v;
        op_e   o;
        longint sa, sb;
        o = OP_ADD;
        if (op == 3'd1) o = OP_SUB;
        else if (op == 3'd3) o = OP_AND;
        else if (op == 3'd4) o = OP_OR;
        else if (op == 3'd5) o = OP_SLT;
        else if (op == 3'd2) begin
            if (fn == 6'd34) o = OP_SUB;
            else if (fn == 6'd36) o = OP_AND;
            else if (fn == 6'd37) o = OP_OR;
            else if (fn == 6'd39) o = OP_NOR;
            else if (fn == 6'd42) o = OP_SLT;
        end
        sa = (a >= 32'h8000_0000) ? longint'(a) - 64'sd4294967296 : longint'(a);
        sb = (b >= 32'h8000_0000) ? longint'(b) - 64'sd4294967296 : longint'(b);
        v.op = op; v.fn = fn; v.a = a; v.b = b; v.aa = aa; v.ab = ab;
        case (o)
            OP_ADD: begin v.e_ctrl = 3'd2; v.e_res = 32'((64'(a) + 64'(b)) % 64'h1_0000_0000); end
            OP_SUB: begin v.e_ctrl = 3'd6; v.e_res = 32'((64'(a) + 64'h1_0000_0000 - 64'(b)) % 64'h1_0000_0000); end
            OP_AND: begin v.e_ctrl = 3'd0; v.e_res = a & b; end
            OP_OR:  begin v.e_ctrl = 3'd1; v.e_res = a | b; end
            OP_NOR: begin v.e_ctrl = 3'd4; v.e_res = ~(a | b); end
            default: begin v.e_ctrl = 3'd7; v.e_res = (sa < sb) ? 32'd1 : 32'd0; end
        endcase
        v.e_zero = (v.e_res == 32'd0);
        v.e_sum  = 32'((64'(aa) + 64'(ab)) % 64'h1_0000_0000);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        alu_op = v.op; funct = v.fn; alu_a = v.a; alu_b = v.b; add_a = v.aa; add_b = v.ab;
    endtask

    task automatic check_out(input string tag, input vec_t v);
        check({tag, ".alu_ctrl"},   {29'd0, alu_ctrl}, {29'd0, v.e_ctrl});
        check({tag, ".alu_result"}, alu_result, v.e_res);
        check({tag, ".zero"},       {31'd0, zero}, {31'd0, v.e_zero});
        check({tag, ".add_sum"},    add_sum, v.e_sum);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".alu_ctrl"},   {29'd0, alu_ctrl}, 32'd0);
        check({tag, ".alu_result"}, alu_result, 32'd0);
        check({tag, ".zero"},       {31'd0, zero}, 32'd0);
        check({tag, ".add_sum"},    add_sum, 32'd0);
    endtask

    initial begin
        vec_t v;
        vec_t prev;
        bit   have_prev;

        reset = 1'b1;
        drive(mk(3'd0, 6'd0, 32'd3, 32'd4, 32'd5, 32'd6, 3'd0, 32'd0, 1'b0, 32'd0));
        @(posedge clk); #1;
        check_all_zero("reset_hold");

        // Directed table, applied back-to-back: each result is checked one edge later.
        tbl.push_back(mk(3'b010, 6'b100000, 32'd5, 32'd7, 32'd40, 32'h10, 3'b010, 32'd12, 1'b0, 32'd56));
        tbl.push_back(mk(3'b001, 6'b000000, 32'h1234, 32'h1234, 32'hFFFF_FFFC, 32'd8, 3'b110, 32'd0, 1'b1, 32'd4));
        tbl.push_back(mk(3'b001, 6'b000000, 32'd0, 32'd1, 32'd0, 32'd0, 3'b110, 32'hFFFF_FFFF, 1'b0, 32'd0));
        tbl.push_back(mk(3'b010, 6'b101010, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'd2, 3'b111, 32'd1, 1'b0, 32'd3));
        tbl.push_back(mk(3'b010, 6'b101010, 32'd1, 32'hFFFF_FFFF, 32'd9, 32'd1, 3'b111, 32'd0, 1'b1, 32'd10));
        tbl.push_back(mk(3'b010, 6'b100100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 32'd0, 3'b000, 32'hF000_F000, 1'b0, 32'd0));
        tbl.push_back(mk(3'b010, 6'b100101, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd1, 32'd1, 3'b001, 32'hFFF0_FFF0, 1'b0, 32'd2));
        tbl.push_back(mk(3'b010, 6'b100111, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd2, 32'd2, 3'b100, 32'h000F_000F, 1'b0, 32'd4));
        tbl.push_back(mk(3'b010, 6'b000000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd3, 32'd3, 3'b010, 32'hEFF1_EFF0, 1'b0, 32'd6));
        tbl.push_back(mk(3'b000, 6'b100010, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 32'h8000_0000, 3'b010, 32'h8000_0000, 1'b0, 32'd0));
        tbl.push_back(mk(3'b010, 6'b100010, 32'd10, 32'd3, 32'd4, 32'd4, 3'b110, 32'd7, 1'b0, 32'd8));
        tbl.push_back(mk(3'b011, 6'b100101, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd5, 32'd5, 3'b000, 32'hF000_F000, 1'b0, 32'd10));
        tbl.push_back(mk(3'b100, 6'b100100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd6, 32'd6, 3'b001, 32'hFFF0_FFF0, 1'b0, 32'd12));
        tbl.push_back(mk(3'b101, 6'b000000, 32'h8000_0000, 32'h7FFF_FFFF, 32'd7, 32'd7, 3'b111, 32'd1, 1'b0, 32'd14));
        tbl.push_back(mk(3'b110, 6'b101010, 32'd2, 32'd3, 32'd8, 32'd8, 3'b010, 32'd5, 1'b0, 32'd16));
        tbl.push_back(mk(3'b111, 6'b100010, 32'hFFFF_FFFF, 32'd1, 32'd9, 32'd9, 3'b010, 32'd0, 1'b1, 32'd18));
        tbl.push_back(mk(3'b010, 6'b100000, 32'd100, 32'd23, 32'd40, 32'h10, 3'b010, 32'd123, 1'b0, 32'd56));

        // Release reset mid-cycle; the first edge afterwards loads the first vector.
        #2;
        reset = 1'b0;
        drive(tbl[0]);
        @(posedge clk); #1;
        check_out("first_after_reset", tbl[0]);
        for (int i = 1; i < tbl.size(); i++) begin
            drive(tbl[i]);
            @(posedge clk); #1;
            check_out($sformatf("tbl%0d", i), tbl[i]);
        end

        // Asynchronous reset with nonzero outputs: must clear before the next edge.
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        @(posedge clk); #1;
        check_all_zero("reset_held_edge");
        v = mk(3'b001, 6'd0, 32'd9, 32'd9, 32'd1, 32'd1, 3'b110, 32'd0, 1'b1, 32'd2);
        drive(v);
        reset = 1'b0;
        @(posedge clk); #1;
        check_out("reload_after_reset", v);

        // Randomized back-to-back operands against the reference model.
        have_prev = 1'b0;
        for (int i = 0; i < 400; i++) begin
            logic [5:0]  fn;
            logic [31:0] ra, rb;
            case ($urandom_range(0, 7))
                0: fn = 6'b100000; 1: fn = 6'b100010; 2: fn = 6'b100100;
                3: fn = 6'b100101; 4: fn = 6'b100111; 5: fn = 6'b101010;
                default: fn = 6'($urandom);
            endcase
            ra = $urandom;
            rb = ($urandom_range(0, 4) == 0) ? ra : 32'($urandom);
            if ($urandom_range(0, 9) == 0) ra = 32'h7FFF_FFFF;
            if ($urandom_range(0, 9) == 0) rb = 32'h8000_0000;
            v = model(3'($urandom), fn, ra, rb, $urandom, $urandom);
            drive(v);
            @(posedge clk); #1;
            check_out($sformatf("rand%0d", i), v);
            prev = v;
            have_prev = 1'b1;
        end

        // Idle inputs held: registered outputs stay at the last computed value.
        if (have_prev) begin
            @(posedge clk); #1;
            check_out("hold_inputs", prev);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
